// File: rtl/move_sequencer_if.sv
// rtl/move_sequencer_if.sv - segment write channel from the message parser into the move sequencer
interface move_sequencer_if #(
  parameter int DUR_W = 64,
  parameter int INC_W = 64
);
  logic                    wr_valid;
  logic                    wr_ready;
  logic                    wr_dir;
  logic [DUR_W-1:0]        wr_duration;
  logic signed [INC_W-1:0] wr_increment;
  logic signed [INC_W-1:0] wr_incrementincrement;

  modport master (
    output wr_valid, wr_dir, wr_duration, wr_increment, wr_incrementincrement,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_dir, wr_duration, wr_increment, wr_incrementincrement,
    output wr_ready
  );
endinterface

// File: rtl/move_sequencer.sv
// rtl/move_sequencer.sv - ring-buffered move segment queue issuing to the DDA executor with start/done/abort
module move_sequencer #(
  parameter int MOVE_BUFFER_BITS = 2,
  parameter int DUR_W = 64,
  parameter int INC_W = 64
) (
  input  logic                        clk,
  input  logic                        resetn,
  move_sequencer_if.slave             wr,
  input  logic                        abort,
  output logic                        mv_start,
  output logic                        mv_dir,
  output logic [DUR_W-1:0]            mv_duration,
  output logic signed [INC_W-1:0]     mv_increment,
  output logic signed [INC_W-1:0]     mv_incrementincrement,
  output logic                        mv_abort,
  input  logic                        mv_done,
  output logic [MOVE_BUFFER_BITS:0]   level,
  output logic                        busy,
  output logic [31:0]                 moves_completed
);
  localparam int DEPTH = 1 << MOVE_BUFFER_BITS;
  localparam logic [MOVE_BUFFER_BITS:0] FULL_LEVEL = (MOVE_BUFFER_BITS + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, ABORT} state_t;

  state_t                      state;
  logic [MOVE_BUFFER_BITS:0]   wptr;
  logic [MOVE_BUFFER_BITS:0]   rptr;
  logic [MOVE_BUFFER_BITS-1:0] widx;
  logic [MOVE_BUFFER_BITS-1:0] ridx;

  logic                    mem_dir      [DEPTH];
  logic [DUR_W-1:0]        mem_duration [DEPTH];
  logic signed [INC_W-1:0] mem_inc      [DEPTH];
  logic signed [INC_W-1:0] mem_incinc   [DEPTH];

  logic full;
  logic accept;
  logic push;
  logic pop;
  logic flush;
  logic done_ok;

  assign widx  = wptr[MOVE_BUFFER_BITS-1:0];
  assign ridx  = rptr[MOVE_BUFFER_BITS-1:0];
  assign level = wptr - rptr;
  assign full  = (level == FULL_LEVEL);
  assign busy  = (state != IDLE);

  assign wr.wr_ready = resetn & ~full & ~abort & (state != ABORT);
  assign accept      = wr.wr_valid & wr.wr_ready;
  // Zero-length segments complete the handshake but never occupy a slot.
  assign push        = accept & (wr.wr_duration != '0);

  // A done coinciding with our own start pulse cannot belong to the new move.
  assign done_ok = mv_done & ~mv_start;
  assign flush   = abort & (state != ABORT);
  assign pop     = ~abort & (level != '0) &
                   ((state == IDLE) | ((state == RUN) & done_ok));

  always_ff @(posedge clk) begin
    if (push) begin
      mem_dir[widx]      <= wr.wr_dir;
      mem_duration[widx] <= wr.wr_duration;
      mem_inc[widx]      <= wr.wr_increment;
      mem_incinc[widx]   <= wr.wr_incrementincrement;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state                 <= IDLE;
      wptr                  <= '0;
      rptr                  <= '0;
      mv_start              <= 1'b0;
      mv_abort              <= 1'b0;
      mv_dir                <= 1'b0;
      mv_duration           <= '0;
      mv_increment          <= '0;
      mv_incrementincrement <= '0;
      moves_completed       <= '0;
    end else begin
      mv_start <= pop;

      if (push) begin
        wptr <= wptr + 1'b1;
      end
      // push and flush are exclusive because abort forces wr_ready low
      if (flush) begin
        rptr <= wptr;
      end else if (pop) begin
        rptr <= rptr + 1'b1;
      end

      if (pop) begin
        mv_dir                <= mem_dir[ridx];
        mv_duration           <= mem_duration[ridx];
        mv_increment          <= mem_inc[ridx];
        mv_incrementincrement <= mem_incinc[ridx];
      end

      case (state)
        IDLE: begin
          if (pop) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (done_ok) begin
            moves_completed <= moves_completed + 32'd1;
            if (!pop) begin
              state <= IDLE;
            end
          end else if (abort) begin
            mv_abort <= 1'b1;
            state    <= ABORT;
          end
        end
        ABORT: begin
          if (mv_done) begin
            mv_abort <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_move_sequencer.sv
// tb/tb_move_sequencer.sv - self-checking bench for move_sequencer against a queue-based reference model
module tb_move_sequencer;
  logic        clk;
  logic        resetn;
  logic        abort;
  logic        mv_start;
  logic        mv_dir;
  logic [63:0] mv_duration;
  logic signed [63:0] mv_increment;
  logic signed [63:0] mv_incrementincrement;
  logic        mv_abort;
  logic        mv_done;
  logic [2:0]  level;
  logic        busy;
  logic [31:0] moves_completed;

  move_sequencer_if #(.DUR_W(64), .INC_W(64)) wr_if ();

  move_sequencer #(.MOVE_BUFFER_BITS(2), .DUR_W(64), .INC_W(64)) dut (
    .clk                   (clk),
    .resetn                (resetn),
    .wr                    (wr_if),
    .abort                 (abort),
    .mv_start              (mv_start),
    .mv_dir                (mv_dir),
    .mv_duration           (mv_duration),
    .mv_increment          (mv_increment),
    .mv_incrementincrement (mv_incrementincrement),
    .mv_abort              (mv_abort),
    .mv_done               (mv_done),
    .level                 (level),
    .busy                  (busy),
    .moves_completed       (moves_completed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  // Reference model: a plain queue of segments plus what the executor is doing.
  typedef struct packed {
    logic        dir;
    logic [63:0] dur;
    logic [63:0] inc;
    logic [63:0] incinc;
  } seg_t;

  seg_t        q[$];
  seg_t        cur;
  bit          running;
  bit          aborting;
  bit          e_start;
  logic [31:0] completed;
  bit          cmp_en = 0;

  task automatic m_reset();
    q.delete();
    cur       = '0;
    running   = 0;
    aborting  = 0;
    e_start   = 0;
    completed = '0;
  endtask

  task automatic m_step();
    bit   accept, issue_ok, was_aborting, done_seen;
    seg_t s;
    was_aborting = aborting;
    done_seen    = mv_done && !e_start;
    accept       = wr_if.wr_valid && !abort && !aborting && (q.size() < 4);
    issue_ok     = !abort && !aborting && (!running || done_seen);
    if (aborting) begin
      if (mv_done) aborting = 0;
    end else if (running && done_seen) begin
      completed = completed + 1;
      running   = 0;
    end else if (running && abort) begin
      aborting = 1;
      running  = 0;
    end
    if (abort && !was_aborting) q.delete();
    e_start = 0;
    if (issue_ok && q.size() > 0) begin
      cur     = q.pop_front();
      e_start = 1;
      running = 1;
    end
    if (accept && wr_if.wr_duration != 64'd0) begin
      s.dir    = wr_if.wr_dir;
      s.dur    = wr_if.wr_duration;
      s.inc    = wr_if.wr_increment;
      s.incinc = wr_if.wr_incrementincrement;
      q.push_back(s);
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) m_reset();
      else m_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("m_wr_ready", {63'd0, wr_if.wr_ready},
            {63'd0, resetn && !abort && !aborting && (q.size() < 4)});
        chk("m_level",    {61'd0, level}, 64'(q.size()));
        chk("m_busy",     {63'd0, busy}, {63'd0, running || aborting});
        chk("m_start",    {63'd0, mv_start}, {63'd0, e_start});
        chk("m_abort",    {63'd0, mv_abort}, {63'd0, aborting});
        chk("m_moves",    {32'd0, moves_completed}, {32'd0, completed});
        chk("m_dir",      {63'd0, mv_dir}, {63'd0, cur.dir});
        chk("m_dur",      mv_duration, cur.dur);
        chk("m_inc",      mv_increment, cur.inc);
        chk("m_incinc",   mv_incrementincrement, cur.incinc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_seg(input logic d, input logic [63:0] dur, input logic [63:0] inc, input logic [63:0] ii);
    wr_if.wr_dir                = d;
    wr_if.wr_duration           = dur;
    wr_if.wr_increment          = inc;
    wr_if.wr_incrementincrement = ii;
    wr_if.wr_valid              = 1'b1;
    tick();
    wr_if.wr_valid              = 1'b0;
  endtask

  task automatic done_pulse();
    if (mv_start) tick();
    mv_done = 1'b1;
    tick();
    mv_done = 1'b0;
  endtask

  task automatic wait_start();
    int n = 0;
    while (!mv_start && n < 10) begin
      tick();
      n++;
    end
    chk("start_seen", {63'd0, mv_start}, 64'd1);
  endtask

  logic [31:0] saved;

  initial begin
    resetn                      = 1'b0;
    abort                       = 1'b0;
    mv_done                     = 1'b0;
    wr_if.wr_valid              = 1'b0;
    wr_if.wr_dir                = 1'b0;
    wr_if.wr_duration           = '0;
    wr_if.wr_increment          = '0;
    wr_if.wr_incrementincrement = '0;
    tick();
    tick();
    cmp_en = 1;
    chk("rst_ready", {63'd0, wr_if.wr_ready}, 64'd0);
    chk("rst_level", {61'd0, level}, 64'd0);
    chk("rst_moves", {32'd0, moves_completed}, 64'd0);
    resetn = 1'b1;
    #1;
    chk("rel_ready", {63'd0, wr_if.wr_ready}, 64'd1);

    // single segment
    wr_seg(1'b1, 64'd100, 64'd5, -64'sd1);
    chk("t1_level1", {61'd0, level}, 64'd1);
    chk("t1_nostart", {63'd0, mv_start}, 64'd0);
    tick();
    chk("t1_start", {63'd0, mv_start}, 64'd1);
    chk("t1_dir", {63'd0, mv_dir}, 64'd1);
    chk("t1_dur", mv_duration, 64'd100);
    chk("t1_inc", mv_increment, 64'd5);
    chk("t1_incinc", mv_incrementincrement, -64'sd1);
    chk("t1_level0", {61'd0, level}, 64'd0);
    chk("t1_busy", {63'd0, busy}, 64'd1);
    tick();
    done_pulse();
    chk("t1_moves", {32'd0, moves_completed}, 64'd1);
    chk("t1_idle", {63'd0, busy}, 64'd0);

    // fill the queue while the executor is held
    for (int i = 0; i < 5; i++) wr_seg(i[0], 64'(10 + i), 64'(i), 64'(2 * i));
    chk("t2_level4", {61'd0, level}, 64'd4);
    chk("t2_full_ready", {63'd0, wr_if.wr_ready}, 64'd0);
    done_pulse();
    chk("t2_b2b_start", {63'd0, mv_start}, 64'd1);
    chk("t2_order", mv_duration, 64'd11);
    chk("t2_level3", {61'd0, level}, 64'd3);
    wr_seg(1'b1, 64'd15, 64'd7, 64'd8);
    wr_if.wr_dir = 1'b0; wr_if.wr_duration = 64'd16; wr_if.wr_valid = 1'b1;
    #1;
    chk("t2_7th_ready", {63'd0, wr_if.wr_ready}, 64'd0);
    tick();
    wr_if.wr_valid = 1'b0;
    chk("t2_7th_level", {61'd0, level}, 64'd4);
    for (int i = 0; i < 5; i++) done_pulse();
    tick();
    chk("t2_moves", {32'd0, moves_completed}, 64'd7);
    chk("t2_idle", {63'd0, busy}, 64'd0);

    // zero-duration write is swallowed
    wr_seg(1'b0, 64'd7, 64'd1, 64'd1);
    wr_seg(1'b1, 64'd0, 64'd2, 64'd2);
    chk("t3_zero_level", {61'd0, level}, 64'd0);
    wr_seg(1'b1, 64'd9, 64'd3, 64'd3);
    chk("t3_level1", {61'd0, level}, 64'd1);
    done_pulse();
    chk("t3_second", mv_duration, 64'd9);
    done_pulse();
    tick();
    chk("t3_nostart", {63'd0, mv_start}, 64'd0);
    chk("t3_idle", {63'd0, busy}, 64'd0);

    // abort during RUN with three queued
    saved = moves_completed;
    for (int i = 0; i < 4; i++) wr_seg(1'b1, 64'(20 + i), 64'd1, 64'd0);
    tick();
    abort = 1'b1;
    #1;
    chk("t4_ready_abort", {63'd0, wr_if.wr_ready}, 64'd0);
    tick();
    abort = 1'b0;
    chk("t4_level0", {61'd0, level}, 64'd0);
    chk("t4_mv_abort", {63'd0, mv_abort}, 64'd1);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_held", {63'd0, mv_abort}, 64'd1);
    chk("t4_ready_low", {63'd0, wr_if.wr_ready}, 64'd0);
    done_pulse();
    chk("t4_released", {63'd0, mv_abort}, 64'd0);
    chk("t4_ready_back", {63'd0, wr_if.wr_ready}, 64'd1);
    chk("t4_moves", {32'd0, moves_completed}, {32'd0, saved});

    // abort and write together in IDLE
    wr_if.wr_dir = 1'b1; wr_if.wr_duration = 64'd33; wr_if.wr_valid = 1'b1;
    abort = 1'b1;
    #1;
    chk("t5_ready", {63'd0, wr_if.wr_ready}, 64'd0);
    tick();
    wr_if.wr_valid = 1'b0;
    abort = 1'b0;
    chk("t5_level", {61'd0, level}, 64'd0);
    tick();
    chk("t5_nostart", {63'd0, mv_start}, 64'd0);
    chk("t5_noabort", {63'd0, mv_abort}, 64'd0);

    // abort coinciding with done in RUN counts as completion
    saved = moves_completed;
    wr_seg(1'b0, 64'd44, 64'd4, 64'd4);
    wait_start();
    tick();
    mv_done = 1'b1;
    abort = 1'b1;
    tick();
    mv_done = 1'b0;
    abort = 1'b0;
    chk("t6_noabort", {63'd0, mv_abort}, 64'd0);
    chk("t6_idle", {63'd0, busy}, 64'd0);
    chk("t6_moves", {32'd0, moves_completed}, {32'd0, saved + 32'd1});

    // asynchronous reset mid-RUN
    for (int i = 0; i < 3; i++) wr_seg(1'b1, 64'(50 + i), 64'd6, 64'd6);
    chk("t7_level2", {61'd0, level}, 64'd2);
    #2;
    resetn = 1'b0;
    #1;
    chk("t7_start0", {63'd0, mv_start}, 64'd0);
    chk("t7_busy0", {63'd0, busy}, 64'd0);
    chk("t7_level0", {61'd0, level}, 64'd0);
    chk("t7_moves0", {32'd0, moves_completed}, 64'd0);
    chk("t7_dur0", mv_duration, 64'd0);
    chk("t7_dir0", {63'd0, mv_dir}, 64'd0);
    chk("t7_ready0", {63'd0, wr_if.wr_ready}, 64'd0);
    tick();
    tick();
    resetn = 1'b1;
    #1;
    chk("t7_ready1", {63'd0, wr_if.wr_ready}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t7_quiet", {63'd0, mv_start}, 64'd0);
    end
    wr_seg(1'b0, 64'd77, 64'd1, 64'd2);
    wait_start();
    chk("t7_new_dur", mv_duration, 64'd77);
    tick();
    done_pulse();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
